// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared types and constants for the RGB fade sequencer
package rgb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FADE,
        ST_HOLD
    } fsm_state_e;

    localparam int COLOR_W = 8;
    localparam int RGB_W   = 3 * COLOR_W;

    // Colour word packing: {R, G, B}
    localparam int R_LSB = 2 * COLOR_W;
    localparam int G_LSB = COLOR_W;
    localparam int B_LSB = 0;

    localparam int DEFAULT_DEPTH = 4;
    localparam logic [RGB_W-1:0] DEFAULT_TABLE [DEFAULT_DEPTH] = '{
        24'h000000,
        24'h050000,
        24'h000500,
        24'h000005
    };

    function automatic logic [RGB_W-1:0] default_color(input int idx);
        logic [RGB_W-1:0] color;
        color = '0;
        if (idx >= 0 && idx < DEFAULT_DEPTH) begin
            color = DEFAULT_TABLE[idx[1:0]];
        end
        return color;
    endfunction

endpackage

// File: rtl/rgb_channel_ramp.sv
// rtl/rgb_channel_ramp.sv - one 8-bit duty channel stepping by 1 toward its target
module rgb_channel_ramp
    import rgb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    input  logic [COLOR_W-1:0] target,
    output logic [COLOR_W-1:0] value,
    output logic               at_target
);

    logic [COLOR_W-1:0] value_q;
    logic [COLOR_W-1:0] value_d;

    assign at_target = (value_q == target);
    assign value     = value_q;

    // Moving only while unequal means the value can never overshoot or wrap.
    always_comb begin
        value_d = value_q;
        if (step_en && !at_target) begin
            if (value_q < target) begin
                value_d = value_q + COLOR_W'(1);
            end else begin
                value_d = value_q - COLOR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - colour table, fade/hold FSM and step counter driving R/G/B duty
module rgb_fade_sequencer
    import rgb_pkg::*;
#(
    parameter int NUM_STEPS  = 4,
    parameter int HOLD_TICKS = 1000,
    parameter int ADDR_W     = $clog2(NUM_STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [23:0]       cfg_data,
    output logic [7:0]        color_r,
    output logic [7:0]        color_g,
    output logic [7:0]        color_b,
    output logic [ADDR_W-1:0] step,
    output logic              step_done
);

    localparam int                HOLD_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(NUM_STEPS - 1);

    logic [RGB_W-1:0]  table_q [NUM_STEPS];
    logic [RGB_W-1:0]  table_d [NUM_STEPS];
    fsm_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic              step_done_q, step_done_d;

    logic [RGB_W-1:0]  target;
    logic              r_at, g_at, b_at, all_at;
    logic              fade_en;

    // Reads the registered table, so a same-edge write only affects later ticks.
    assign target  = table_q[step_q];
    assign all_at  = r_at & g_at & b_at;
    assign fade_en = run && tick_en && (state_q == ST_FADE) && !all_at;

    rgb_channel_ramp u_ramp_r (
        .clk       (clk),
        .rst       (rst),
        .step_en   (fade_en),
        .target    (target[R_LSB +: COLOR_W]),
        .value     (color_r),
        .at_target (r_at)
    );

    rgb_channel_ramp u_ramp_g (
        .clk       (clk),
        .rst       (rst),
        .step_en   (fade_en),
        .target    (target[G_LSB +: COLOR_W]),
        .value     (color_g),
        .at_target (g_at)
    );

    rgb_channel_ramp u_ramp_b (
        .clk       (clk),
        .rst       (rst),
        .step_en   (fade_en),
        .target    (target[B_LSB +: COLOR_W]),
        .value     (color_b),
        .at_target (b_at)
    );

    always_comb begin
        table_d = table_q;
        if (cfg_we && (int'(cfg_addr) < NUM_STEPS)) begin
            table_d[cfg_addr] = cfg_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        step_d      = step_q;
        step_done_d = 1'b0;
        if (!run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FADE;
                ST_FADE: begin
                    if (tick_en && all_at) begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (tick_en) begin
                        if (hold_q == '0) begin
                            step_d      = (step_q == LAST_STEP) ? '0 : step_q + ADDR_W'(1);
                            step_done_d = 1'b1;
                            state_d     = ST_FADE;
                        end else begin
                            hold_d = hold_q - HOLD_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            step_q      <= '0;
            step_done_q <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                table_q[i] <= default_color(i);
            end
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            step_done_q <= step_done_d;
            table_q     <= table_d;
        end
    end

    assign step      = step_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb/tb_rgb_fade_sequencer.sv - self-checking bench for rgb_fade_sequencer
module tb_rgb_fade_sequencer;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_en;
    logic        run;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic [7:0]  color_r, color_g, color_b;
    logic [1:0]  step;
    logic        step_done;

    logic        run2;
    logic        cfg_we2;
    logic [1:0]  cfg_addr2;
    logic [23:0] cfg_data2;
    logic [7:0]  r2, g2, b2;
    logic [1:0]  step2;
    logic        done2;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(.NUM_STEPS(4), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .run(run),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .color_r(color_r), .color_g(color_g), .color_b(color_b),
        .step(step), .step_done(step_done)
    );

    rgb_fade_sequencer #(.NUM_STEPS(3), .HOLD_TICKS(HOLD)) dut3 (
        .clk(clk), .rst(rst), .tick_en(tick_en), .run(run2),
        .cfg_we(cfg_we2), .cfg_addr(cfg_addr2), .cfg_data(cfg_data2),
        .color_r(r2), .color_g(g2), .color_b(b2),
        .step(step2), .step_done(done2)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [23:0] m_tab [4];
    int          m_col [3];
    int          m_step;
    bit          m_hold;
    int          m_left;
    bit          m_run;
    bit          m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_tab[0] = 24'h000000;
        m_tab[1] = 24'h050000;
        m_tab[2] = 24'h000500;
        m_tab[3] = 24'h000005;
        for (int c = 0; c < 3; c++) m_col[c] = 0;
        m_step = 0;
        m_hold = 0;
        m_left = 0;
        m_done = 0;
        m_run  = 0;
    endtask

    task automatic model_tick();
        int  t [3];
        bool_arrived: begin end
        m_done = 0;
        if (!m_run) return;
        t[0] = int'(m_tab[m_step][23:16]);
        t[1] = int'(m_tab[m_step][15:8]);
        t[2] = int'(m_tab[m_step][7:0]);
        if (!m_hold) begin
            if (m_col[0] == t[0] && m_col[1] == t[1] && m_col[2] == t[2]) begin
                m_hold = 1;
                m_left = HOLD - 1;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (m_col[c] < t[c]) m_col[c]++;
                    else if (m_col[c] > t[c]) m_col[c]--;
                end
            end
        end else if (m_left == 0) begin
            m_step = (m_step + 1) % 4;
            m_done = 1;
            m_hold = 0;
        end else begin
            m_left--;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_r"}, color_r, m_col[0]);
        check({tag, "_g"}, color_g, m_col[1]);
        check({tag, "_b"}, color_b, m_col[2]);
        check({tag, "_step"}, step, m_step);
        check({tag, "_done"}, step_done, m_done);
    endtask

    task automatic tick(input string tag, input int gap, input bit we = 1'b0,
                        input logic [1:0] a = 2'd0, input logic [23:0] d = 24'd0);
        tick_en  = 1'b1;
        cfg_we   = we;
        cfg_addr = a;
        cfg_data = d;
        model_tick();
        if (we) m_tab[a] = d;
        clk1();
        tick_en = 1'b0;
        cfg_we  = 1'b0;
        check_all(tag);
        for (int i = 0; i < gap; i++) begin
            clk1();
            if (i == 0) check({tag, "_pulse"}, step_done, 1'b0);
        end
    endtask

    task automatic write(input logic [1:0] a, input logic [23:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        m_tab[a] = d;
        clk1();
        cfg_we = 1'b0;
    endtask

    task automatic set_run(input bit v);
        run   = v;
        m_run = v;
        if (!v) m_hold = 0;
        clk1();
        clk1();
    endtask

    task automatic run_until_step(input string tag, input int tgt, input int bound);
        int n = 0;
        while (m_step != tgt && n < bound) begin
            tick(tag, 1);
            n++;
        end
        check({tag, "_reached"}, step, tgt);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run     = 1'b0;
        run2    = 1'b0;
        tick_en = 1'b0;
        cfg_we  = 1'b0;
        cfg_we2 = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        cfg_addr2 = '0;
        cfg_data2 = '0;
        clk1();
        clk1();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [23:0] rand_color();
        return {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
    endfunction

    initial begin
        do_reset();
        check("rst_r", color_r, 0);
        check("rst_g", color_g, 0);
        check("rst_b", color_b, 0);
        check("rst_step", step, 0);
        check("rst_done", step_done, 0);

        // Reset arrival and first upward ramp, tick every 4 clocks
        set_run(1'b1);
        for (int k = 1; k <= 11; k++) begin
            tick($sformatf("t1_tick%0d", k), 3);
            if (k == 3)  check("t1_step1", step, 1);
            if (k == 8)  check("t1_r5", color_r, 5);
            if (k == 11) check("t1_step2", step, 2);
        end

        // Downward ramp across the wrap from entry 3 to entry 0
        run_until_step("t2_to3", 3, 40);
        run_until_step("t2_to0", 0, 40);
        check("t2_wrap_b5", color_b, 5);
        for (int i = 0; i < 5; i++) begin
            tick($sformatf("t2_down%0d", i), 1);
            check($sformatf("t2_b_%0d", i), color_b, 4 - i);
        end

        // Full-scale ramp
        write(2'd1, 24'hFF00FF);
        run_until_step("t3_to1", 1, 10);
        for (int i = 0; i < 255; i++) tick($sformatf("t3_ramp%0d", i), 1);
        check("t3_r_ff", color_r, 8'hFF);
        check("t3_g_00", color_g, 8'h00);
        check("t3_b_ff", color_b, 8'hFF);
        tick("t3_no_overshoot", 1);
        check("t3_r_still_ff", color_r, 8'hFF);

        // Pause and resume mid-fade
        do_reset();
        set_run(1'b1);
        run_until_step("t4_to1", 1, 10);
        for (int i = 0; i < 3; i++) tick($sformatf("t4_up%0d", i), 1);
        check("t4_r3", color_r, 3);
        set_run(1'b0);
        for (int i = 0; i < 10; i++) tick($sformatf("t4_paused%0d", i), 1);
        check("t4_r_held", color_r, 3);
        set_run(1'b1);
        tick("t4_resume", 1);
        check("t4_r4", color_r, 4);

        // Write the current target together with a tick
        tick("t5_wr_tick", 1, 1'b1, 2'd1, 24'h000000);
        check("t5_old_target", color_r, 5);
        tick("t5_new_tick", 1);
        check("t5_new_target", color_r, 4);

        // Arrive at a non-zero colour, then reset asynchronously mid-hold
        write(2'd1, 24'h040302);
        for (int n = 0; n < 20 && !m_hold; n++) tick($sformatf("t6_fade%0d", n), 1);
        tick("t6_holding", 1);
        check("t6_pre_r", color_r, 4);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_async_r", color_r, 0);
        check("t6_async_g", color_g, 0);
        check("t6_async_b", color_b, 0);
        check("t6_async_step", step, 0);
        check("t6_async_done", step_done, 0);
        for (int i = 0; i < 4; i++) begin
            clk1();
            check($sformatf("t6_rst_done%0d", i), step_done, 0);
        end
        rst = 1'b0;
        model_reset();
        set_run(1'b1);
        run_until_step("t6_restored", 1, 10);
        for (int i = 0; i < 5; i++) tick($sformatf("t6_tab%0d", i), 1);
        check("t6_tab_r5", color_r, 5);
        check("t6_tab_g0", color_g, 0);

        // Out-of-range write on the three-entry instance
        set_run(1'b0);
        cfg_we2   = 1'b1;
        cfg_addr2 = 2'd3;
        cfg_data2 = 24'hABCDEF;
        clk1();
        cfg_we2 = 1'b0;
        run2    = 1'b1;
        clk1();
        clk1();
        for (int k = 1; k <= 24; k++) begin
            tick_en = 1'b1;
            clk1();
            tick_en = 1'b0;
            if (k == 3)  check("t5b_step1", step2, 1);
            if (k == 8)  check("t5b_r5", r2, 5);
            if (k == 11) check("t5b_step2", step2, 2);
            if (k == 16) check("t5b_g5", g2, 5);
            if (k == 16) check("t5b_r0", r2, 0);
            if (k == 19) check("t5b_wrap_step", step2, 0);
            if (k == 19) check("t5b_wrap_done", done2, 1);
            if (k == 24) check("t5b_g0", g2, 0);
            if (k == 24) check("t5b_b0", b2, 0);
            clk1();
        end
        run2 = 1'b0;

        // Randomized writes, tick spacing and run toggles
        set_run(1'b1);
        for (int it = 0; it < 200; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                write(2'($urandom_range(0, 3)), rand_color());
            end else if (sel == 1) begin
                set_run(!m_run);
            end else if (sel == 2) begin
                tick($sformatf("rnd_wt%0d", it), $urandom_range(0, 3), 1'b1,
                     2'($urandom_range(0, 3)), rand_color());
            end else begin
                tick($sformatf("rnd_t%0d", it), $urandom_range(0, 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
# rgb_fade_sequencer

Controller that drives the three 8-bit duty inputs of the R/G/B PWM channels from a small programmable colour table. It steps through the table in order, ramping each channel linearly toward the next colour, holding the colour for a programmable number of ticks, then advancing with wrap-around. It sits between the clock-divider tick source and the three PWM instances, and replaces ad-hoc table indexing at the top level.

## Interface

**Parameters**
- `NUM_STEPS`, default 4: number of colour table entries; must be ≥ 2.
- `HOLD_TICKS`, default 1000: ticks a colour is held after arrival; must be ≥ 1.
- `ADDR_W`, default `$clog2(NUM_STEPS)`: table address width.

**Ports**
- `clk`, in, 1: single system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick_en`, in, 1: one-cycle strobe from the divider; all ramp and hold progress happens only on cycles where it is high.
- `run`, in, 1: sequencing enable. Level-sensitive.
- `cfg_we`, in, 1: table write strobe.
- `cfg_addr`, in, `ADDR_W`: table entry to write.
- `cfg_data`, in, 24: colour `{R[23:16], G[15:8], B[7:0]}`.
- `color_r`, out, 8: red duty, registered.
- `color_g`, out, 8: green duty, registered.
- `color_b`, out, 8: blue duty, registered.
- `step`, out, `ADDR_W`: index of the current target entry.
- `step_done`, out, 1: one-cycle pulse when `step` advances.

## Operation

**Reset values**
- All `color_*` = 0; `step` = 0; `step_done` = 0; state = IDLE; hold counter = 0.
- Table = {0x000000, 0x050000, 0x000500, 0x000005}, then 0 for entries ≥ 4.

**States**
- **IDLE**
  - Outputs frozen.
  - `run`=1 → FADE on the next clock; no tick is required for this transition.
- **FADE**, on `tick_en`:
  - If all channels already equal `table[step]`: go to HOLD and load the counter with `HOLD_TICKS-1`.
  - Otherwise, each unequal channel moves by exactly 1 toward its target, independently. Equal channels are untouched.
- **HOLD**, on `tick_en`:
  - If counter = 0: set `step` to `step+1` (wrapping `NUM_STEPS-1`→0), pulse `step_done`, go to FADE.
  - Otherwise: decrement the counter.
- **Any state with `run`=0**
  - Go to IDLE next cycle; the hold counter and `step` are retained.
  - When `run` returns, the sequencer re-enters FADE and re-checks arrival, so an interrupted HOLD restarts its count.

**Arithmetic**
- Channel compare is unsigned 8-bit.
- A step never overshoots or wraps (0x00 toward 0xFF counts up).

**Config port**
- A write occurs on any cycle with `cfg_we`=1, in any state.
- Writes with `cfg_addr` ≥ `NUM_STEPS` are ignored.
- Writing the current target entry mid-FADE or mid-HOLD takes effect from the next cycle; HOLD does not re-check the target.

**Simultaneous write and tick**
- The tick evaluates against the pre-write table contents.
- The write lands in the same edge.

## Timing

- All outputs are registered and update on the clock edge that samples `tick_en`=1, so latency from tick to output is 1 clock.
- `step_done` is high for exactly one clock, coincident with the new `step` value.
- Ticks arrive no more often than every 2 clocks; behaviour with back-to-back ticks is still defined by the rules above.
- Reset mid-operation returns all outputs and the table to their reset values asynchronously. The first FADE occurs only after `rst` falls and `run`=1.
- Dwell per entry = max(|Δch|) + 1 + `HOLD_TICKS` ticks: the ramp, one arrival-check tick, then the hold.

## Structure

- Shared package `rgb_pkg`:
  - the state enum (IDLE/FADE/HOLD);
  - `COLOR_W`=8;
  - the 24-bit colour packing localparams;
  - the default table constant.
- One sub-module, `rgb_channel_ramp`, instantiated three times:
  - inputs: `clk`, `rst`, step enable, 8-bit target;
  - outputs: 8-bit value and `at_target`.
- The top level handles the table registers, FSM, hold counter and `step`.

## Test plan

1. **Reset defaults and reset arrival**
   - Stimulus: `HOLD_TICKS`=2, assert reset, then `run`=1 with a tick every 4 clocks.
   - Required: outputs 0. Tick 1 → HOLD; tick 3 → `step`=1 with `step_done` pulse. Ticks 4–8 → `color_r` 1,2,3,4,5. Tick 9 → HOLD. Tick 11 → `step`=2.
2. **Downward ramp and full wrap**
   - Required: from 0x000005 (`step`=3), the next advance gives `step`=0, and `color_b` ramps down 4,3,2,1,0.
3. **Full-scale ramp**
   - Stimulus: write entry 1 = 0xFF00FF.
   - Required: red and blue reach 0xFF after exactly 255 ticks, green stays 0, no overshoot.
4. **Pause and resume**
   - Stimulus: drop `run` mid-FADE at `color_r`=3 for 10 ticks, then raise it.
   - Required: `color_r` holds at 3, then resumes at 4.
5. **Config port edge cases**
   - Stimulus: write to the current target mid-ramp, simultaneous with a tick.
   - Required: that tick uses the old target and the next tick uses the new one.
   - Stimulus: write to `cfg_addr` ≥ `NUM_STEPS` (with `NUM_STEPS`=3).
   - Required: the table is unchanged.
6. **Asynchronous reset mid-HOLD**
   - Required: outputs clear without a clock edge, the table is restored, and `step_done` never pulses.
